// File: rtl/nios2_oci_dct_trace_capture.sv
// DCT trace capture FIFO with a capture/flush/done sequencer and a saturating drop counter.
// Optional DCT_TRACE_WRAP_EN: a full FIFO overwrites its oldest entry instead of dropping the newest word.
module nios2_oci_dct_trace_capture #(
    parameter int DCT_W  = 30,
    parameter int CNT_W  = 4,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       capture_en,
    input  logic                       dct_valid,
    input  logic [DCT_W-1:0]           dct_buffer,
    input  logic [CNT_W-1:0]           dct_count,
    input  logic                       test_ending,
    input  logic                       test_has_ended,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [CNT_W+DCT_W-1:0]     rd_data,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_count,
    output logic                       done,
    output logic [1:0]                 state
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_FLUSH   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                    r_state, w_next;
    logic [CNT_W+DCT_W-1:0]    r_mem [DEPTH];
    logic [AW-1:0]             r_wptr, r_rptr;
    logic [AW:0]               r_fill;
    logic                      r_overflow, r_done;
    logic [DROP_W-1:0]         r_drop;

    logic w_cand, w_full, w_pop, w_push, w_drop, w_radv, w_inc, w_dec, w_arm;

    assign w_cand = (r_state == S_CAPTURE) && dct_valid && (dct_count != '0);
    assign w_full = (r_fill == FULL_LVL);
    assign w_pop  = rd_en && (r_fill != '0);
    assign w_drop = w_cand && w_full && !w_pop;
    assign w_arm  = (r_state == S_IDLE) && capture_en && !test_has_ended;

`ifdef DCT_TRACE_WRAP_EN
    // Overwrite: write lands on the oldest slot (wptr == rptr when full), so the read side steps past it.
    assign w_push = w_cand;
    assign w_radv = w_pop || w_drop;
`else
    assign w_push = w_cand && (!w_full || w_pop);
    assign w_radv = w_pop;
`endif

    assign w_inc = w_push && !w_pop && !w_full;
    assign w_dec = w_pop && !w_push;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {dct_count, dct_buffer};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_radv) r_rptr <= r_rptr + 1'b1;
            if (w_inc)      r_fill <= r_fill + 1'b1;
            else if (w_dec) r_fill <= r_fill - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else if (w_arm) begin
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop != '1) r_drop <= r_drop + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        if (test_has_ended) begin
            w_next = S_DONE;
        end else begin
            case (r_state)
                S_IDLE:    if (capture_en) w_next = S_CAPTURE;
                S_CAPTURE: begin
                    if (test_ending)      w_next = S_FLUSH;
                    else if (!capture_en) w_next = S_IDLE;
                end
                // The last pop empties the FIFO at this edge, so DONE arrives with it.
                S_FLUSH:   if (r_fill == '0 || (r_fill == 1 && w_pop)) w_next = S_DONE;
                S_DONE:    if (!capture_en) w_next = S_IDLE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (w_next == S_DONE);
        end
    end

    assign rd_valid   = (r_fill != '0);
    assign rd_data    = rd_valid ? r_mem[r_rptr] : '0;
    assign fill_level = r_fill;
    assign overflow   = r_overflow;
    assign drop_count = r_drop;
    assign done       = r_done;
    assign state      = r_state;
endmodule

// File: tb/tb_nios2_oci_dct_trace_capture.sv
// Directed bench for the DCT trace capture FIFO and its sequencer.
module tb_nios2_oci_dct_trace_capture;
    localparam int DCT_W = 30, CNT_W = 4, DEPTH = 16, DROP_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             capture_en, dct_valid, test_ending, test_has_ended, rd_en;
    logic [DCT_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;
    logic             rd_valid, overflow, done;
    logic [CNT_W+DCT_W-1:0] rd_data;
    logic [4:0]       fill_level;
    logic [DROP_W-1:0] drop_count;
    logic [1:0]       state;

    int checks = 0;
    int errors = 0;

    nios2_oci_dct_trace_capture #(.DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset_n(reset_n), .capture_en(capture_en), .dct_valid(dct_valid),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_ending(test_ending),
        .test_has_ended(test_has_ended), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .fill_level(fill_level), .overflow(overflow), .drop_count(drop_count), .done(done),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] c, input logic [29:0] b);
        dct_valid = 1'b1; dct_count = c; dct_buffer = b;
        tick();
        dct_valid = 1'b0; dct_count = '0; dct_buffer = '0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; capture_en = 0; dct_valid = 0; dct_buffer = '0; dct_count = '0;
        test_ending = 0; test_has_ended = 0; rd_en = 0;
        tick(); tick();
        checks++;
        if ({state, fill_level, rd_valid, overflow, drop_count, done} !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset: state=%0d fill=%0d rdv=%0d rdd=%h ovf=%0d drop=%0d done=%0d, want all 0",
                     state, fill_level, rd_valid, rd_data, overflow, drop_count, done);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        capture_en = 1'b1;
        tick();
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL arm_state: got %0d want 1", state); end
        push(4'd1, 30'h1); push(4'd2, 30'h2); push(4'd3, 30'h3);
        checks++;
        if (fill_level !== 5'd3) begin errors++; $display("FAIL basic_fill: got %0d want 3", fill_level); end
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (rd_data !== {4'(i), 30'(i)} || rd_valid !== 1'b1) begin
                errors++; $display("FAIL basic_pop%0d: got %h v=%0d want %h", i, rd_data, rd_valid, {4'(i), 30'(i)});
            end
            pop();
        end
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: rd_valid=%0d want 0", rd_valid); end
    endtask

    task automatic test_ignored();
        push(4'd0, 30'h55);
        checks++;
        if (fill_level !== 5'd0 || drop_count !== '0) begin
            errors++; $display("FAIL zero_count: fill=%0d drop=%0d want 0/0", fill_level, drop_count);
        end
        capture_en = 1'b0;
        tick();
        checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL to_idle: got %0d want 0", state); end
        push(4'd7, 30'h66);
        checks++;
        if (fill_level !== 5'd0 || drop_count !== '0 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL idle_word: fill=%0d drop=%0d rdv=%0d want 0/0/0", fill_level, drop_count, rd_valid);
        end
    endtask

    task automatic test_overflow();
        logic [29:0] first;
`ifdef DCT_TRACE_WRAP_EN
        first = 30'd2;
`else
        first = 30'd0;
`endif
        capture_en = 1'b1;
        tick();
        for (int i = 0; i < DEPTH + 2; i++) push(4'd1, 30'(i));
        checks++;
        if (fill_level !== 5'd16 || overflow !== 1'b1 || drop_count !== 16'd2) begin
            errors++; $display("FAIL ovf_status: fill=%0d ovf=%0d drop=%0d want 16/1/2", fill_level, overflow, drop_count);
        end
        checks++;
        if (rd_data !== {4'd1, first}) begin errors++; $display("FAIL ovf_head: got %h want %h", rd_data, {4'd1, first}); end
        // Full with a pop and a write together: write goes in, nothing dropped.
        rd_en = 1'b1;
        push(4'd5, 30'h100);
        rd_en = 1'b0;
        checks++;
        if (fill_level !== 5'd16 || drop_count !== 16'd2) begin
            errors++; $display("FAIL full_pushpop: fill=%0d drop=%0d want 16/2", fill_level, drop_count);
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            checks++;
            if (rd_data !== {4'd1, 30'(first + 30'(i) + 30'd1)}) begin
                errors++; $display("FAIL drain%0d: got %h want %h", i, rd_data, {4'd1, 30'(first + 30'(i) + 30'd1)});
            end
            pop();
        end
        checks++;
        if (rd_data !== {4'd5, 30'h100} || fill_level !== 5'd1) begin
            errors++; $display("FAIL tail: got %h fill=%0d want %h/1", rd_data, fill_level, {4'd5, 30'h100});
        end
        pop();
        capture_en = 1'b0; tick();
        capture_en = 1'b1; tick();
        checks++;
        if (overflow !== 1'b0 || drop_count !== '0 || state !== 2'd1) begin
            errors++; $display("FAIL rearm_clear: ovf=%0d drop=%0d state=%0d want 0/0/1", overflow, drop_count, state);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) push(4'd3, 30'(30'h40 + 30'(i)));
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL flush_state: got %0d want 2", state); end
        pop(); pop(); pop();
        checks++;
        if (state !== 2'd2 || done !== 1'b0) begin
            errors++; $display("FAIL flush_hold: state=%0d done=%0d want 2/0", state, done);
        end
        pop();
        checks++;
        if (state !== 2'd3 || done !== 1'b1 || rd_valid !== 1'b0) begin
            errors++; $display("FAIL flush_done: state=%0d done=%0d rdv=%0d want 3/1/0", state, done, rd_valid);
        end
        capture_en = 1'b0;
        tick();
        checks++;
        if (state !== 2'd0 || done !== 1'b0) begin
            errors++; $display("FAIL done_idle: state=%0d done=%0d want 0/0", state, done);
        end
    endtask

    task automatic test_abort();
        capture_en = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) push(4'd2, 30'(30'hA0 + 30'(i)));
        test_has_ended = 1'b1;
        tick();
        test_has_ended = 1'b0;
        checks++;
        if (state !== 2'd3 || done !== 1'b1 || fill_level !== 5'd5) begin
            errors++; $display("FAIL abort: state=%0d done=%0d fill=%0d want 3/1/5", state, done, fill_level);
        end
        pop();
        checks++;
        if (rd_data !== {4'd2, 30'hA1} || fill_level !== 5'd4) begin
            errors++; $display("FAIL abort_drain: got %h fill=%0d want %h/4", rd_data, fill_level, {4'd2, 30'hA1});
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({state, fill_level, rd_valid, overflow, drop_count, done} !== '0 || rd_data !== '0) begin
            errors++; $display("FAIL async_reset: state=%0d fill=%0d rdv=%0d rdd=%h done=%0d want all 0",
                               state, fill_level, rd_valid, rd_data, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ignored();
        test_overflow();
        test_flush();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/nios2_oci_dct_trace_capture.md
Name: nios2_oci_dct_trace_capture

Overview:
Parametrised successor to the OCI test-bench DCT monitor stub. It captures debug-core trace (DCT) words and their valid-count into an on-chip FIFO, and a simulation harness or the JTAG debug path drains that FIFO. It runs a capture/flush/done sequence driven by the test_ending and test_has_ended strobes, and counts dropped words. It sits beside the Nios II OCI block, on the same clock.

Parameters:
DCT_W, 30, width of dct_buffer.
CNT_W, 4, width of dct_count.
DEPTH, 16, FIFO entries; power of two, minimum 2.
DROP_W, 16, width of the saturating drop counter.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset_n  in  1  reset, asynchronous assert, active-low.
capture_en  in  1  arms capture; level-sensitive.
dct_valid  in  1  dct_buffer and dct_count are valid this cycle.
dct_buffer  in  DCT_W  trace payload.
dct_count  in  CNT_W  number of valid trace slots in dct_buffer.
test_ending  in  1  single-cycle strobe: test is finishing, flush requested.
test_has_ended  in  1  level: test is over, abort immediately.
rd_en  in  1  pop the head entry.
rd_valid  out  1  FIFO not empty.
rd_data  out  CNT_W+DCT_W  head entry, packed as {count, buffer}.
fill_level  out  clog2(DEPTH)+1  current number of entries, 0..DEPTH.
overflow  out  1  sticky: at least one word has been dropped.
drop_count  out  DROP_W  number of dropped words; saturates.
done  out  1  high only in state DONE.
state  out  2  IDLE=0, CAPTURE=1, FLUSH=2, DONE=3.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - FIFO pointers cleared; fill_level=0, rd_valid=0, rd_data=0.
  - overflow=0, drop_count=0, done=0, state=IDLE.
  - Reset mid-operation discards all FIFO contents.
- Write acceptance. A word is a write candidate only when state==CAPTURE, dct_valid=1 and dct_count!=0.
  - Words with dct_count==0 are ignored silently; they are not counted as drops.
  - Valid words arriving in IDLE, FLUSH or DONE are ignored and not counted.
- Read side is show-ahead:
  - rd_valid = (fill_level!=0); rd_data shows the head combinationally from the storage array.
  - rd_en with rd_valid=1 pops the head at the clock edge. rd_en with rd_valid=0 is ignored; pointers do not move.
  - Reads are allowed in every state except reset.
- Full: a write candidate while fill_level==DEPTH is accepted only if a pop happens in the same cycle; fill_level is then unchanged.
  - Otherwise the word is dropped: overflow<=1 and drop_count increments, saturating at all-ones.
- Simultaneous push and pop when not full: both happen, fill_level is unchanged.
- Simultaneous push and pop when empty: the push happens; the pop is ignored because rd_valid=0.
- Pointers: clog2(DEPTH) bits, wrapping modulo DEPTH. fill_level is a separate counter.
- Write latency: an accepted word is visible on rd_data/rd_valid the cycle after it is written, if the FIFO was empty.
- FSM:
  - IDLE -> CAPTURE when capture_en=1. In IDLE, an arming cycle also clears overflow and drop_count; FIFO contents are preserved.
  - CAPTURE -> FLUSH on test_ending=1; a word arriving in that same cycle is still accepted.
  - CAPTURE -> IDLE when capture_en=0 with no test_ending.
  - FLUSH -> DONE when fill_level==0, or when the cycle's pop empties the FIFO (then DONE on the next edge).
  - Any state -> DONE when test_has_ended=1. This has priority over all other transitions.
  - DONE -> IDLE when capture_en=0 and test_has_ended=0.
- done, state, overflow and drop_count are all registered outputs.

Optional Feature:
Macro: DCT_TRACE_WRAP_EN.
- Defined: the FIFO runs as a circular trace buffer. A write candidate when full, with no pop, overwrites the oldest entry: the read pointer advances, fill_level stays at DEPTH, overflow<=1, and drop_count increments (counting overwritten words).
- Not defined: drop-newest behaviour as described in Behaviour.

Test Plan:
- Reset then capture_en=1, 3 words (count=1,2,3; buffer=0x1,0x2,0x3) -> state=1, fill_level=3; pops return {1,0x1},{2,0x2},{3,0x3} in order, then rd_valid=0.
- Word with dct_count=0 in CAPTURE, and a valid word in IDLE -> fill_level unchanged; drop_count=0.
- Without the macro: write DEPTH+2 words (buffer=0..17) with no reads -> fill_level=16, overflow=1, drop_count=2, head=0. With the macro: same stimulus gives head=2 and drop_count=2.
- Full FIFO with rd_en=1 and a valid write in the same cycle -> fill_level stays 16, new word at the tail, drop_count unchanged.
- 4 entries held, pulse test_ending -> state=2; pop 4 times -> state=3 on the edge after the last pop, done=1; capture_en=0 -> state=0.
- test_has_ended=1 while in CAPTURE with 5 entries -> state=3 next cycle, FIFO still drainable. Then reset_n=0 mid-drain -> all outputs return to 0 asynchronously.
